// File: rtl/spm_arbiter.sv
// spm_arbiter: round-robin arbiter sharing one signed serial-parallel multiplier
// among NUM_REQ clients. Grants one client at a time, captures its operands,
// pulses spm_start, waits for spm_done and returns the product with a one-hot
// response strobe.
// Optional feature: define SPM_ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT
// cycles that answers with rsp_err=1 and a zero product.
module spm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] a_flat,
  input  logic [NUM_REQ*W-1:0] b_flat,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]       rsp_product,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 spm_start,
  output logic [W-1:0]         spm_x,
  output logic [W-1:0]         spm_y,
  input  logic [2*W-1:0]       spm_out,
  input  logic                 spm_done
);

  localparam int          IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0]       rsp_product_q, rsp_product_d;
  logic                 busy_q, busy_d;
  logic                 spm_start_q, spm_start_d;
  logic [W-1:0]         spm_x_q, spm_x_d;
  logic [W-1:0]         spm_y_q, spm_y_d;

`ifdef SPM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rsp_err_q, rsp_err_d;
`endif

  logic [IW-1:0]        win_idx;
  logic                 win_found;
  int unsigned          cand;

  // Round-robin search: first requesting client at or above ptr, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NR) cand = cand - NR;
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    spm_start_d   = 1'b0;
    rsp_product_d = rsp_product_q;
    spm_x_d       = spm_x_q;
    spm_y_d       = spm_y_q;
`ifdef SPM_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_err_d     = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          idx_d          = win_idx;
          gnt_d[win_idx] = 1'b1;
          spm_x_d        = a_flat[win_idx*W +: W];
          spm_y_d        = b_flat[win_idx*W +: W];
          state_d        = S_START;
        end
      end
      S_START: begin
        spm_start_d = 1'b1;
`ifdef SPM_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (spm_done) begin
          rsp_product_d      = spm_out;
          rsp_valid_d[idx_q] = 1'b1;
`ifdef SPM_ARB_TIMEOUT_EN
          rsp_err_d          = 1'b0;
`endif
          state_d            = S_RESP;
        end
`ifdef SPM_ARB_TIMEOUT_EN
        // The count starts at 0 in the first WAIT cycle, so the response lands
        // exactly TIMEOUT cycles after the spm_start cycle.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_product_d      = '0;
          rsp_valid_d[idx_q] = 1'b1;
          rsp_err_d          = 1'b1;
          state_d            = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      busy_q        <= 1'b0;
      spm_start_q   <= 1'b0;
      spm_x_q       <= '0;
      spm_y_q       <= '0;
`ifdef SPM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      busy_q        <= busy_d;
      spm_start_q   <= spm_start_d;
      spm_x_q       <= spm_x_d;
      spm_y_q       <= spm_y_d;
`ifdef SPM_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign busy        = busy_q;
  assign spm_start   = spm_start_q;
  assign spm_x       = spm_x_q;
  assign spm_y       = spm_y_q;
`ifdef SPM_ARB_TIMEOUT_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/spm_arbiter.md
# spm_arbiter

Round-robin arbiter that shares one signed serial-parallel multiplier (the SPM sequencing FSM with its `startOperation`/`done` handshake) among `NUM_REQ` requesters. It captures the winning requester's operands and pulses the multiplier start. It then waits for the multiplier's done and returns the signed product with a one-hot response strobe. It sits between client blocks and the single SPM instance, so the multiplier never sees overlapping operations.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `W`, 8: operand width; product is `2*W`.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `SPM_ARB_TIMEOUT_EN`.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in `NUM_REQ`: request per client; held high with operands stable until that client's `rsp_valid`.
- `a_flat` in `NUM_REQ*W`: multiplicand per client, client i at bits `[i*W +: W]`, two's complement.
- `b_flat` in `NUM_REQ*W`: multiplier per client, same packing.
- `gnt` out `NUM_REQ`: one-hot, one-cycle pulse marking which client's operands were captured.
- `rsp_valid` out `NUM_REQ`: one-hot, one-cycle response strobe.
- `rsp_product` out `2*W`: signed product; valid while `rsp_valid` is nonzero, held otherwise.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `spm_start` out 1: one-cycle start pulse to the multiplier.
- `spm_x` out `W`: registered operand to the multiplier.
- `spm_y` out `W`: registered operand to the multiplier.
- `spm_out` in `2*W`: multiplier result.
- `spm_done` in 1: multiplier completion pulse.

## Operation
- States are IDLE, START, WAIT and RESP. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, select a winner by searching from `ptr` upward and wrapping at `NUM_REQ`.
  - Latch `a`/`b` of the winner into `spm_x`/`spm_y`.
  - Store the winner index as `idx` and assert `gnt[idx]`.
  - Next state: START.
- **START**
  - `spm_start=1` for exactly this cycle; `spm_x`/`spm_y` stay held.
  - Clear the watchdog counter.
  - Next state: WAIT.
- **WAIT**
  - `spm_start=0`.
  - When `spm_done=1`: capture `spm_out` into `rsp_product`, set `rsp_valid[idx]=1` and `rsp_err=0`, go to RESP.
- **RESP**
  - `rsp_valid` is high for this cycle only.
  - `ptr <= (idx+1) mod NUM_REQ`.
  - Next state: IDLE.
- Request rules:
  - A client must drop `req` in the cycle after its `rsp_valid`. If `req` is still high when IDLE samples it, that is a new request.
  - `req` changes outside IDLE are ignored until IDLE samples again.
  - Operands are sampled only in IDLE, so a client may change them after its `gnt`.
- Arithmetic: none in this block. The product passes through bit-exact with sign preserved.
- `spm_done` asserted outside WAIT is ignored. If `spm_done` coincides with entry to WAIT, it is accepted on the first WAIT cycle.
- Reset forces the following. If reset arrives mid-operation, the operation is dropped with no response, and the SPM must share `rst`.
  - state = IDLE, `ptr=0`
  - `gnt`, `rsp_valid`, `rsp_product`, `rsp_err`, `busy`, `spm_start`, `spm_x`, `spm_y` = 0

## Timing
- `req` is sampled high at edge N.
  - `gnt` is high during cycle N+1.
  - `spm_start` is high during cycle N+2.
- `spm_done` is sampled at edge M, so `rsp_valid` is high during cycle M+1.
- Overhead is 3 cycles plus the SPM latency.
- Back-to-back: the next `gnt` comes at the earliest 2 cycles after `rsp_valid`.
- With all clients requesting continuously, service is strictly round-robin starting from client 0 after reset.

## Configuration
- `SPM_ARB_TIMEOUT_EN` defined:
  - WAIT counts cycles. On reaching `TIMEOUT` without `spm_done`, go to RESP with `rsp_valid[idx]=1`, `rsp_err=1` and `rsp_product=0`.
  - A late `spm_done` is then ignored.
- `SPM_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Single request: reset, then `req[0]` with 25, 15 → `gnt=0001` at N+1, `spm_start` at N+2, then `rsp_valid=0001` with `rsp_product=375` and `rsp_err=0`.
- Signed operands: client 2 with 100, −2 → `rsp_product=16'hFF38`; client 1 with −64, −2 → `128`.
- Contention: `req=1111` held continuously (clients re-request after each response) → grant order 0, 1, 2, 3, 0; exactly one `spm_start` per grant, never more than one outstanding.
- Pointer wrap: after client 3 is served, `req=1001` → client 0 is granted next; after client 0, `req=1001` → client 3 is granted next.
- Reset mid-operation: drive `rst=0` in WAIT → the next cycle shows all outputs 0 and state IDLE with no `rsp_valid`; after release, `req[1]` with 3, 4 → `rsp_product=12` from a clean restart.
- Timeout (`SPM_ARB_TIMEOUT_EN`, `TIMEOUT=64`): hold `spm_done` low → `rsp_valid` with `rsp_err=1` and product 0 exactly 64 WAIT cycles after `spm_start`; a later `spm_done` pulse produces no response.
